// File: rtl/count_seq_checker.sv
// Receive-side checker for a free-running up-counter stream: acquires lock, then flags breaks in the sequence.
// Optional CNT_CHK_STUCK_EN adds a 'stuck' output and tolerates repeated values while locked.
module count_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERRW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_vld,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] err_val,
  output logic [WIDTH-1:0] exp_count
`ifdef CNT_CHK_STUCK_EN
  ,
  output logic             stuck
`endif
);

  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [RW-1:0] LOCK_V = RW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_ACQUIRE  = 2'd1,
    S_LOCKED   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [RW-1:0]    run_q, run_d;
  logic             err_q, err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] err_val_q, err_val_d;
  logic [WIDTH-1:0] exp_count_q, exp_count_d;
  logic             stuck_q, stuck_d;

  logic [WIDTH-1:0] prev_inc;
  logic [RW-1:0]    run_inc;
  logic             incr_ok;
  logic             repeat_ok;
  logic             mismatch;

  always_comb begin
    prev_inc  = prev_q + 1'b1;
    run_inc   = run_q + 1'b1;
    incr_ok   = (count_in == prev_inc);
`ifdef CNT_CHK_STUCK_EN
    repeat_ok = (count_in == prev_q);
`else
    repeat_ok = 1'b0;
`endif

    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    err_d     = 1'b0;
    stuck_d   = stuck_q;
    mismatch  = 1'b0;

    if (count_vld) begin
      unique case (state_q)
        S_UNLOCKED: begin
          prev_d  = count_in;
          run_d   = '0;
          state_d = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          prev_d = count_in;
          if (incr_ok) begin
            run_d = run_inc;
            if (run_inc == LOCK_V) state_d = S_LOCKED;
          end else begin
            run_d = '0;
          end
        end
        S_LOCKED: begin
          if (incr_ok) begin
            prev_d  = count_in;
            stuck_d = 1'b0;
          end else if (repeat_ok) begin
            // A repeated sample is a stall, not a sequence break; keep lock.
            stuck_d = 1'b1;
          end else begin
            mismatch = 1'b1;
            err_d    = 1'b1;
            prev_d   = count_in;
            run_d    = '0;
            stuck_d  = 1'b0;
            state_d  = S_ACQUIRE;
          end
        end
        default: state_d = S_UNLOCKED;
      endcase
    end

    // Clear and a same-cycle mismatch combine: the new error survives the clear.
    err_cnt_d = clr_err ? '0 : err_cnt_q;
    err_val_d = clr_err ? '0 : err_val_q;
    if (mismatch) begin
      err_val_d = count_in;
      if (clr_err)                err_cnt_d = {{(ERRW-1){1'b0}}, 1'b1};
      else if (err_cnt_q != '1)   err_cnt_d = err_cnt_q + 1'b1;
    end

    exp_count_d = (state_d == S_LOCKED) ? WIDTH'(prev_d + 1'b1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_UNLOCKED;
      prev_q      <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      err_val_q   <= '0;
      exp_count_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      err_val_q   <= err_val_d;
      exp_count_q <= exp_count_d;
      stuck_q     <= stuck_d;
    end
  end

  assign locked    = (state_q == S_LOCKED);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign err_val   = err_val_q;
  assign exp_count = exp_count_q;
`ifdef CNT_CHK_STUCK_EN
  assign stuck     = stuck_q;
`else
  logic unused_stuck;
  assign unused_stuck = stuck_q ^ repeat_ok;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed-vector bench for count_seq_checker (LOCK_CNT=4, ERRW=2) with a queued scoreboard.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_in;
  logic       count_vld;
  logic       clr_err;
  logic       locked;
  logic       err;
  logic [1:0] err_cnt;
  logic [7:0] err_val;
  logic [7:0] exp_count;
  logic       stuck;

  always #5 clk = ~clk;

  count_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERRW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .count_vld (count_vld),
    .clr_err   (clr_err),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_val   (err_val),
    .exp_count (exp_count)
`ifdef CNT_CHK_STUCK_EN
    ,
    .stuck     (stuck)
`endif
  );
`ifndef CNT_CHK_STUCK_EN
  assign stuck = 1'b0;
`endif

  typedef struct {
    int         id;
    logic       locked;
    logic       err;
    logic [1:0] cnt;
    logic [7:0] val;
    logic [7:0] expc;
    logic       stuck;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   vec_id = 0;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] req);
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, req);
    end
  endtask

  // Monitor: outputs are registered, so one expectation retires per cycle, just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        chk("locked",    e.id, {7'd0, locked}, {7'd0, e.locked});
        chk("err",       e.id, {7'd0, err},    {7'd0, e.err});
        chk("err_cnt",   e.id, {6'd0, err_cnt}, {6'd0, e.cnt});
        chk("err_val",   e.id, err_val,   e.val);
        chk("exp_count", e.id, exp_count, e.expc);
`ifdef CNT_CHK_STUCK_EN
        chk("stuck",     e.id, {7'd0, stuck}, {7'd0, e.stuck});
`endif
      end
    end
  end

  task automatic v(input logic r, input logic vd, input logic cl, input logic [7:0] c,
                   input logic l, input logic e, input logic [1:0] ec,
                   input logic [7:0] ev, input logic [7:0] xc, input logic st);
    exp_t x;
    @(negedge clk);
    rst = r; count_vld = vd; clr_err = cl; count_in = c;
    x.id = vec_id; x.locked = l; x.err = e; x.cnt = ec; x.val = ev; x.expc = xc; x.stuck = st;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Four correct increments after base; lock lands on the fourth.
  task automatic relock(input logic [7:0] base, input logic [1:0] ec, input logic [7:0] ev);
    for (int i = 1; i <= 3; i++) v(1, 1, 0, 8'(base + i), 0, 0, ec, ev, 8'h00, 0);
    v(1, 1, 0, 8'(base + 4), 1, 0, ec, ev, 8'(base + 5), 0);
  endtask

  task automatic mm_relock(input logic [7:0] bad, input logic [1:0] ec);
    v(1, 1, 0, bad, 0, 1, ec, bad, 8'h00, 0);
    relock(bad, ec, bad);
  endtask

  initial begin
    rst = 1'b0; count_vld = 1'b0; clr_err = 1'b0; count_in = 8'h00;
    // Reset, with a valid sample that must be ignored.
    v(0, 1, 0, 8'h55, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    // Acquire 0..4 and lock.
    v(1, 1, 0, 8'h00, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    relock(8'h00, 2'd0, 8'h00);
    // Gap of five invalid cycles with junk data keeps lock.
    for (int i = 0; i < 5; i++) v(1, 0, 0, 8'hC3, 1, 0, 2'd0, 8'h00, 8'h05, 0);
    v(1, 1, 0, 8'h05, 1, 0, 2'd0, 8'h00, 8'h06, 0);
    // Wrap-around while locked.
    v(0, 0, 0, 8'h00, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    v(1, 1, 0, 8'hFB, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    relock(8'hFB, 2'd0, 8'h00);
    v(1, 1, 0, 8'h00, 1, 0, 2'd0, 8'h00, 8'h01, 0);
    v(1, 1, 0, 8'h01, 1, 0, 2'd0, 8'h00, 8'h02, 0);
    // Lock at exp 0x10, break with 0x13, relock to exp 0x18.
    v(0, 0, 0, 8'h00, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    v(1, 1, 0, 8'h0B, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    relock(8'h0B, 2'd0, 8'h00);
    mm_relock(8'h13, 2'd1);
    // Saturation at 3 with a pulse on every mismatch.
    mm_relock(8'h40, 2'd2);
    mm_relock(8'h50, 2'd3);
    mm_relock(8'h60, 2'd3);
    mm_relock(8'h70, 2'd3);
    mm_relock(8'h80, 2'd3);
    // Clear colliding with a mismatch, then a plain clear while locked.
    v(1, 1, 1, 8'h99, 0, 1, 2'd1, 8'h99, 8'h00, 0);
    relock(8'h99, 2'd1, 8'h99);
    v(1, 0, 1, 8'h00, 1, 0, 2'd0, 8'h00, 8'h9E, 0);
    // Two errors, then reset wipes everything including history.
    mm_relock(8'hA0, 2'd1);
    mm_relock(8'h07, 2'd2);
    v(0, 1, 0, 8'h0C, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    v(1, 0, 0, 8'h0C, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    v(1, 1, 0, 8'h0D, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    // A break during acquire is not counted.
    v(1, 1, 0, 8'h1B, 0, 0, 2'd0, 8'h00, 8'h00, 0);
    relock(8'h1B, 2'd0, 8'h00);
    v(1, 1, 0, 8'h20, 1, 0, 2'd0, 8'h00, 8'h21, 0);
    // Repeated value while locked.
`ifdef CNT_CHK_STUCK_EN
    v(1, 1, 0, 8'h20, 1, 0, 2'd0, 8'h00, 8'h21, 1);
    v(1, 1, 0, 8'h21, 1, 0, 2'd0, 8'h00, 8'h22, 0);
`else
    v(1, 1, 0, 8'h20, 0, 1, 2'd1, 8'h20, 8'h00, 0);
    v(1, 1, 0, 8'h21, 0, 0, 2'd1, 8'h20, 8'h00, 0);
`endif
    @(negedge clk);
    count_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
